// File: rtl/matmul_pkg.sv
// Shared widths, controller state type and the row-major address helper for matmul_controller.
package matmul_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int IDX_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // Word address of element [row][col] of a dim x dim matrix; wraps at 8 bits.
  function automatic logic [ADDR_W-1:0] idx(input logic [ADDR_W-1:0] base,
                                            input logic [ADDR_W-1:0] row,
                                            input logic [ADDR_W-1:0] col,
                                            input logic [ADDR_W-1:0] dim);
    return base + row * dim + col;
  endfunction

endpackage

// File: rtl/matmul_controller_if.sv
// Four-port data memory signals; the controller is the master, the memory is the slave.
interface matmul_controller_if;
  import matmul_pkg::*;

  logic              write_en0, write_en1, write_en2, write_en3;
  logic [ADDR_W-1:0] addr0, addr1, addr2, addr3;
  logic [DATA_W-1:0] datain0, datain1, datain2, datain3;
  logic [DATA_W-1:0] dataout0, dataout1, dataout2, dataout3;

  modport master (
    output write_en0, write_en1, write_en2, write_en3,
    output addr0, addr1, addr2, addr3,
    output datain0, datain1, datain2, datain3,
    input  dataout0, dataout1, dataout2, dataout3
  );

  modport slave (
    input  write_en0, write_en1, write_en2, write_en3,
    input  addr0, addr1, addr2, addr3,
    input  datain0, datain1, datain2, datain3,
    output dataout0, dataout1, dataout2, dataout3
  );

endinterface

// File: rtl/matmul_controller_mac2.sv
// Two unsigned 16x16 multipliers feeding a wrapping 32-bit accumulator.
module mac2
  import matmul_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] sum_lo
);

  logic [ACC_W-1:0] acc, prod0, prod1, acc_sum;

  always_comb begin
    prod0   = ACC_W'(a0) * ACC_W'(b0);
    prod1   = ACC_W'(a1) * ACC_W'(b1);
    acc_sum = acc + prod0 + prod1;
  end

  // The write-back path needs the sum including the pair arriving in DRAIN, not the stale acc.
  assign sum_lo = acc_sum[DATA_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/matmul_controller.sv
// Sequences dual-element A/B fetches, two-product accumulation and C write-back for C = A x B.
module matmul_controller
  import matmul_pkg::*;
#(
  parameter int DIM    = 4,
  parameter int A_BASE = 0,
  parameter int B_BASE = 64,
  parameter int C_BASE = 128
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  matmul_controller_if.master mem
);

  localparam int SQ = DIM * DIM;

  function automatic bit fits(input int base);
    return (base >= 0) && (base + SQ - 1 <= 255);
  endfunction

  function automatic bit apart(input int x, input int y);
    return (x + SQ <= y) || (y + SQ <= x);
  endfunction

  localparam bit CFG_OK = (DIM % 2 == 0) && (DIM >= 2) && (DIM <= 8) &&
                          fits(A_BASE) && fits(B_BASE) && fits(C_BASE) &&
                          apart(A_BASE, B_BASE) && apart(A_BASE, C_BASE) && apart(B_BASE, C_BASE);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("matmul_controller: DIM must be even in 2..8 and A/B/C regions must fit 8 bits without overlap");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] A_ADDR   = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] B_ADDR   = ADDR_W'(B_BASE);
  localparam logic [ADDR_W-1:0] C_ADDR   = ADDR_W'(C_BASE);
  localparam logic [ADDR_W-1:0] DIM_W    = ADDR_W'(DIM);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0]  LAST_P   = IDX_W'(DIM / 2 - 1);

  state_t            state;
  logic [IDX_W-1:0]  i, j, p, fi, fj, fp;
  logic              armed, fetch_d, last_p, last_j, last_el, fetch_go;
  logic [ADDR_W-1:0] row, col, k0, k1;
  logic [DATA_W-1:0] sum_lo;

  // Reset assertion is asynchronous; release only arms start one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  always_comb begin
    last_p  = (p == LAST_P);
    last_j  = (j == LAST_IDX);
    last_el = last_j && (i == LAST_IDX);
    fetch_go = ((state == IDLE) && start && armed) ||
               ((state == FETCH) && !last_p) ||
               ((state == WRITE) && !last_el);
    fi = i;
    fj = j;
    fp = p + 1'b1;
    if (state == IDLE) begin
      fi = '0;
      fj = '0;
      fp = '0;
    end else if (state == WRITE) begin
      fp = '0;
      fj = last_j ? '0 : j + 1'b1;
      fi = last_j ? i + 1'b1 : i;
    end
    row = ADDR_W'(fi);
    col = ADDR_W'(fj);
    k0  = ADDR_W'({fp, 1'b0});
    k1  = ADDR_W'({fp, 1'b1});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      i             <= '0;
      j             <= '0;
      p             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fetch_d       <= 1'b0;
      mem.write_en0 <= 1'b0;
      mem.datain0   <= '0;
      mem.addr0     <= '0;
      mem.addr1     <= '0;
      mem.addr2     <= '0;
      mem.addr3     <= '0;
    end else begin
      fetch_d       <= (state == FETCH);
      done          <= 1'b0;
      mem.write_en0 <= 1'b0;
      mem.datain0   <= '0;
      mem.addr0     <= fetch_go ? idx(A_ADDR, row, k0, DIM_W) : '0;
      mem.addr1     <= fetch_go ? idx(B_ADDR, k0, col, DIM_W) : '0;
      mem.addr2     <= fetch_go ? idx(A_ADDR, row, k1, DIM_W) : '0;
      mem.addr3     <= fetch_go ? idx(B_ADDR, k1, col, DIM_W) : '0;
      if (fetch_go) begin
        i <= fi;
        j <= fj;
        p <= fp;
      end
      case (state)
        IDLE: begin
          if (fetch_go) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (last_p) state <= DRAIN;
        end
        DRAIN: begin
          state         <= WRITE;
          mem.write_en0 <= 1'b1;
          mem.addr0     <= idx(C_ADDR, ADDR_W'(i), ADDR_W'(j), DIM_W);
          mem.datain0   <= sum_lo;
        end
        WRITE: begin
          if (last_el) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.write_en1 = 1'b0;
  assign mem.write_en2 = 1'b0;
  assign mem.write_en3 = 1'b0;
  assign mem.datain1   = '0;
  assign mem.datain2   = '0;
  assign mem.datain3   = '0;

  mac2 u_mac2 (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == WRITE),
    .enable  (fetch_d),
    .a0      (mem.dataout0),
    .b0      (mem.dataout1),
    .a1      (mem.dataout2),
    .b1      (mem.dataout3),
    .sum_lo  (sum_lo)
  );

endmodule

// File: tb/tb_matmul_controller.sv
// Directed bench for matmul_controller (DIM=4) with a behavioural four-port memory and write log.
module tb_matmul_controller;
  import matmul_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  matmul_controller_if mem_if ();

  matmul_controller #(
    .DIM    (4),
    .A_BASE (0),
    .B_BASE (64),
    .C_BASE (128)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .mem     (mem_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          a_ident;
    logic [15:0] a_val;
    bit          b_ramp;
    logic [15:0] b_val;
    bit          exp_ramp;
    logic [15:0] exp_val;
  } vec_t;

  logic [15:0] ram [256];
  logic [7:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc [$];
  int          done_cyc [$];
  int          edge_no = 0;
  int          stray_we = 0;
  int          applied = 0;
  int          miscompares = 0;

  // Memory model: synchronous read, port-0 writes logged with the absolute edge that captured them.
  always @(posedge clock) begin
    if (mem_if.write_en0) begin
      wr_addr.push_back(mem_if.addr0);
      wr_data.push_back(mem_if.datain0);
      wr_cyc.push_back(edge_no);
    end
    if (mem_if.write_en1 || mem_if.write_en2 || mem_if.write_en3) stray_we <= stray_we + 1;
    if (done) done_cyc.push_back(edge_no);
    mem_if.dataout0 <= ram[mem_if.addr0];
    mem_if.dataout1 <= ram[mem_if.addr1];
    mem_if.dataout2 <= ram[mem_if.addr2];
    mem_if.dataout3 <= ram[mem_if.addr3];
    edge_no <= edge_no + 1;
  end

  function automatic logic [127:0] snap();
    return 128'({busy, done, mem_if.write_en0, mem_if.write_en1, mem_if.write_en2, mem_if.write_en3,
                 mem_if.addr0, mem_if.addr1, mem_if.addr2, mem_if.addr3,
                 mem_if.datain0, mem_if.datain1, mem_if.datain2, mem_if.datain3});
  endfunction

  function automatic logic [127:0] mk(input bit b, input bit d, input bit we0,
                                      input logic [7:0] a0, input logic [7:0] a1,
                                      input logic [7:0] a2, input logic [7:0] a3,
                                      input logic [15:0] d0);
    return 128'({b, d, we0, 3'b000, a0, a1, a2, a3, d0, 48'h0});
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mats(input bit a_ident, input logic [15:0] a_val,
                           input bit b_ramp, input logic [15:0] b_val);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ram[r*4 + c]      = a_ident ? ((r == c) ? 16'd1 : 16'd0) : a_val;
        ram[64 + r*4 + c] = b_ramp ? 16'(r*4 + c + 1) : b_val;
      end
    end
  endtask

  task automatic check_run(input string tag, input bit ramp, input logic [15:0] ev, input int s,
                           input int wl, input int wh, input int dl, input int dh,
                           input int n_wr, input bit exp_done);
    int n_got;
    logic [15:0] want;
    n_got = wh - wl;
    check_output({tag, "_write_count"}, 128'(n_got), 128'(n_wr));
    for (int n = 0; n < n_wr && n < n_got; n++) begin
      want = ramp ? 16'((n + 1) * ev) : ev;
      check_output($sformatf("%s_c%0d_addr", tag, n), 128'(wr_addr[wl+n]), 128'(128 + n));
      check_output($sformatf("%s_c%0d_cycle", tag, n), 128'(wr_cyc[wl+n] - s), 128'(4 * (n + 1)));
      check_output($sformatf("%s_c%0d_data", tag, n), 128'(wr_data[wl+n]), 128'(want));
    end
    check_output({tag, "_done_count"}, 128'(dh - dl), 128'(exp_done ? 1 : 0));
    if (exp_done && dh > dl) check_output({tag, "_done_cycle"}, 128'(done_cyc[dl] - s), 128'(65));
    check_output({tag, "_stray_we"}, 128'(stray_we), 128'(0));
  endtask

  // First element of the identity run, cycle by cycle (cycle n follows edge n-1, start at edge 0).
  task automatic check_probe(input int c);
    case (c)
      1: check_output("c1_fetch_p0", snap(), mk(1, 0, 0, 8'd0, 8'd64, 8'd1, 8'd68, 16'd0));
      2: check_output("c2_fetch_p1", snap(), mk(1, 0, 0, 8'd2, 8'd72, 8'd3, 8'd76, 16'd0));
      3: check_output("c3_drain", snap(), mk(1, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0));
      4: check_output("c4_write", snap(), mk(1, 0, 1, 8'd128, 8'd0, 8'd0, 8'd0, 16'd1));
      5: check_output("c5_fetch_e1", snap(), mk(1, 0, 0, 8'd0, 8'd65, 8'd1, 8'd69, 16'd0));
      default: ;
    endcase
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_output({tag, "_done_seen"}, 128'(done), 128'(1));
    @(negedge clock);
  endtask

  task automatic apply_stimulus(input string tag, input bit ramp, input logic [15:0] ev,
                                input bit probe, input bit mid_start);
    int s, wl, dl, last_c;
    last_c = 0;
    @(negedge clock);
    start = 1'b1;
    s  = edge_no;
    wl = wr_addr.size();
    dl = done_cyc.size();
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c < 300; c++) begin
      if (probe) check_probe(c);
      if (mid_start) start = (c == 20);
      if (done === 1'b1) begin
        last_c = c;
        break;
      end
      @(negedge clock);
    end
    start = 1'b0;
    @(negedge clock);
    check_output({tag, "_done_at"}, 128'(last_c), 128'(65));
    check_run(tag, ramp, ev, s, wl, wr_addr.size(), dl, done_cyc.size(), 16, 1'b1);
  endtask

  vec_t vecs [5];

  initial begin
    int s, wl, dl, wm, dm;

    vecs[0] = '{"identity",   1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0001};
    vecs[1] = '{"const_1x2",  1'b0, 16'h0001, 1'b0, 16'h0002, 1'b0, 16'h0008};
    vecs[2] = '{"ovf_0100",   1'b0, 16'h0100, 1'b0, 16'h0100, 1'b0, 16'h0000};
    vecs[3] = '{"wrap_ffff1", 1'b0, 16'hFFFF, 1'b0, 16'h0001, 1'b0, 16'hFFFC};
    vecs[4] = '{"wrap_ffff2", 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 16'h0004};

    for (int a = 0; a < 256; a++) ram[a] = 16'h0000;
    load_mats(1'b1, 16'h0, 1'b1, 16'h0);

    // Reset held with start high: everything idle, start only taken on the second edge after release.
    reset_n = 1'b0;
    start   = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check_output("reset_zero", snap(), '0);
    end
    reset_n = 1'b1;
    s = edge_no + 1;
    @(negedge clock);
    check_output("release_edge1_busy", 128'(busy), 128'(0));
    @(negedge clock);
    check_output("release_edge2_busy", 128'(busy), 128'(1));
    start = 1'b0;
    wait_done("startup");
    check_run("startup", 1'b1, 16'd1, s, 0, wr_addr.size(), 0, done_cyc.size(), 16, 1'b1);

    for (int v = 0; v < 5; v++) begin
      load_mats(vecs[v].a_ident, vecs[v].a_val, vecs[v].b_ramp, vecs[v].b_val);
      apply_stimulus(vecs[v].name, vecs[v].exp_ramp, vecs[v].exp_val, v == 0, 1'b0);
    end

    load_mats(1'b1, 16'h0, 1'b1, 16'h0);
    apply_stimulus("mid_start", 1'b1, 16'd1, 1'b0, 1'b1);

    // start held across DONE: the second run's first FETCH lands in cycle 67.
    load_mats(1'b0, 16'h0001, 1'b0, 16'h0002);
    @(negedge clock);
    start = 1'b1;
    s  = edge_no;
    wl = wr_addr.size();
    dl = done_cyc.size();
    for (int c = 1; c <= 67; c++) begin
      @(negedge clock);
      if (c == 65) check_output("hold_done_c65", 128'(done), 128'(1));
      if (c == 66) check_output("hold_idle_c66", 128'({busy, done}), 128'(0));
      if (c == 67) check_output("hold_fetch_c67", 128'({busy, mem_if.addr1}), 128'({1'b1, 8'd64}));
    end
    start = 1'b0;
    wm = wr_addr.size();
    dm = done_cyc.size();
    wait_done("hold_run2");
    check_run("hold_run1", 1'b0, 16'd8, s, wl, wm, dl, dm, 16, 1'b1);
    check_run("hold_run2", 1'b0, 16'd8, s + 66, wm, wr_addr.size(), dm, done_cyc.size(), 16, 1'b1);

    // Reset dropped during FETCH of element 5 (cycle 21).
    load_mats(1'b1, 16'h0, 1'b1, 16'h0);
    @(negedge clock);
    start = 1'b1;
    s  = edge_no;
    wl = wr_addr.size();
    dl = done_cyc.size();
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    check_output("rst_pre_busy", 128'(busy), 128'(1));
    reset_n = 1'b0;
    #1;
    check_output("rst_async_zero", snap(), '0);
    repeat (5) @(negedge clock);
    check_output("rst_held_zero", snap(), '0);
    check_run("rst_partial", 1'b1, 16'd1, s, wl, wr_addr.size(), dl, done_cyc.size(), 5, 1'b0);
    reset_n = 1'b1;
    apply_stimulus("after_rst", 1'b1, 16'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_controller.md
# matmul_controller

Sequencer that drives the four-port 256×16 data memory to compute C = A × B for square DIM×DIM matrices held at fixed base addresses. It issues dual-element fetches on ports 0–3, multiply-accumulates two products per cycle, and writes each result element back through port 0. It sits between the host-side start/done control and the memory's port signals, and is the only master of those ports while busy.

## Interface
- DIM, 4: matrix dimension; even, 2..8
- A_BASE, 0: word address of A[0][0], row-major
- B_BASE, 64: word address of B[0][0], row-major
- C_BASE, 128: word address of C[0][0], row-major
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a multiply; sampled only in IDLE
- busy  out  1  high in FETCH, DRAIN and WRITE
- done  out  1  one-cycle pulse after the last C write
- write_en0..write_en3  out  1 each  memory write enables; only write_en0 is ever driven high
- addr0..addr3  out  8 each  memory port addresses
- datain0..datain3  out  16 each  write data; datain1..3 tied 0
- dataout0..dataout3  in  16 each  registered memory read data, valid one cycle after address

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: all outputs 0. start=1 → FETCH with i=j=0, p=0, acc=0.
- FETCH (DIM/2 cycles, p = 0..DIM/2-1), for k0=2p, k1=2p+1:
  - addr0=A_BASE+i·DIM+k0, addr1=B_BASE+k0·DIM+j
  - addr2=A_BASE+i·DIM+k1, addr3=B_BASE+k1·DIM+j
  - All write_en 0. After p=DIM/2-1 → DRAIN.
- Accumulate: in every cycle following a FETCH cycle, acc += dataout0·dataout1 + dataout2·dataout3.
  - Unsigned 16×16→32 products; 32-bit acc, wraps mod 2^32.
- DRAIN: one cycle; addresses 0; last pair accumulated → WRITE.
- WRITE: one cycle.
  - write_en0=1, addr0=C_BASE+i·DIM+j, datain0=acc[15:0] (mod 2^16, no saturation).
  - acc cleared; j advances, then i when j wraps DIM-1→0.
  - Last element (i=j=DIM-1) → DONE; otherwise → FETCH with p=0.
- DONE: done=1 for one cycle, busy=0, ports idle → IDLE.
- start while busy or in DONE: ignored. start held high: a new run begins from the IDLE cycle following DONE.
- Address arithmetic is 8-bit. Elaboration fails if DIM is odd or outside 2..8, or if any of the three DIM² regions exceeds 255 or overlaps another.

## Timing
- Reset (async assert): state IDLE. busy, done, all write_en, addr and datain 0. acc, i, j, p cleared. Release is synchronised internally; first start is accepted on the second rising edge after deassertion.
- Per element: DIM/2+2 cycles. Total run: DIM²·(DIM/2+2) cycles from the FETCH entry edge to the last WRITE, then one DONE cycle.
  - DIM=4: start sampled at edge 0; FETCH at cycles 1–2, DRAIN at 3, WRITE at 4.
  - Last write at cycle 64; done at cycle 65; IDLE at 66.
- Read latency is 1 cycle. The controller never writes and reads the same port in the same cycle, and never reads C during a run.
- Reset mid-run: abort immediately. Outputs go to 0 asynchronously. Previously written C elements remain and no further writes occur. done does not pulse.

## Structure
- Package matmul_pkg: ADDR_W=8, DATA_W=16, ACC_W=32, state enum, and the address-helper function idx(base,row,col,dim).
- Sub-module mac2: two unsigned multipliers plus a 32-bit accumulator, with clear and enable inputs. The FSM, counters and address generation stay in matmul_controller.

## Test plan
- Reset: hold reset_n=0 with start=1 → every output is 0. busy stays 0 until start is sampled after release.
- Identity: DIM=4, A=I, B=1..16 row-major.
  - C[128..143] = 1..16.
  - Writes land on cycles 4, 8, …, 64 in ascending address order.
  - done pulses only in cycle 65.
- Constant: A all 1, B all 2 → every C word = 8. write_en1..3 are never asserted.
- Overflow: A all 0x0100, B all 0x0100 → each acc = 0x40000, so every C word = 0x0000. A all 0xFFFF, B all 0x0001 → C = 0xFFFC.
- Start handling: pulse start again mid-run → no restart, still exactly 16 writes. Hold start high → a second run's first FETCH begins in cycle 67.
- Mid-run reset: drop reset_n during FETCH of element 5.
  - Outputs are 0 in the same cycle.
  - Only C[128..132] were written, with no write after reset.
  - A fresh run after release produces the correct full result.
